// File: rtl/mem_access_pkg.sv
// mem_access_pkg: access-size type, FSM encodings and store-lane helpers for the memory stage.
package mem_access_pkg;
   typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
   typedef logic [1:0] mem_state_t;
   localparam mem_state_t S_IDLE = 2'd0;
   localparam mem_state_t S_REQ  = 2'd1;
   localparam mem_state_t S_WAIT = 2'd2;
   localparam mem_state_t S_DONE = 2'd3;

   function automatic logic [7:0] mem_strobe(msize_t s, logic [2:0] a);
      return s == MSIZE1 ? 8'h01 << a :
             s == MSIZE2 ? 8'h03 << {a[2:1], 1'b0} :
             s == MSIZE4 ? 8'h0F << {a[2], 2'b00} : 8'hFF;
   endfunction

   function automatic logic mem_misaligned(msize_t s, logic [2:0] a);
      return (s == MSIZE2 && a[0]) || (s == MSIZE4 && a[1:0] != 2'b00) || (s == MSIZE8 && a != 3'b000);
   endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: execute request, data-bus and result handshakes of the memory stage.
interface mem_access_if;
   import mem_access_pkg::*;
   logic        in_valid, in_ready, in_is_load, in_is_store, in_unsigned;
   logic [63:0] in_addr, in_wdata;
   msize_t      in_msize;
   logic        dreq_valid;
   logic [63:0] dreq_addr, dreq_data;
   msize_t      dreq_size;
   logic [7:0]  dreq_strobe;
   logic        dresp_addr_ok, dresp_data_ok;
   logic [63:0] dresp_data;
   logic        out_valid, out_ready, out_unsigned, out_misalign, out_bus_err;
   logic [63:0] out_rd;
   logic [2:0]  out_addr;
   msize_t      out_msize;

   modport slave (
      input  in_valid, in_is_load, in_is_store, in_addr, in_wdata, in_msize, in_unsigned,
      input  dresp_addr_ok, dresp_data_ok, dresp_data, out_ready,
      output in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output out_valid, out_rd, out_addr, out_msize, out_unsigned, out_misalign, out_bus_err
   );
   modport master (
      output in_valid, in_is_load, in_is_store, in_addr, in_wdata, in_msize, in_unsigned,
      output dresp_addr_ok, dresp_data_ok, dresp_data, out_ready,
      input  in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  out_valid, out_rd, out_addr, out_msize, out_unsigned, out_misalign, out_bus_err
   );
endinterface

// File: rtl/mem_access_store_align.sv
// mem_store_align: byte-lane strobe and data shift for a store at addr[2:0].
module mem_store_align
   import mem_access_pkg::*;
(
   input  msize_t      msize,
   input  logic [2:0]  addr,
   input  logic [63:0] wdata,
   output logic [7:0]  strobe,
   output logic [63:0] data
);
   assign strobe = mem_strobe(msize, addr);
   assign data   = wdata << {addr, 3'b000};
endmodule

// File: rtl/mem_access.sv
// mem_access: memory-stage front-end; issues one bus access per accepted request and
// holds the raw bus word plus extraction tags until the consumer takes it.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 0,
   parameter int CNT_W          = 16
) (
   input logic          clk,
   input logic          rst_n,
   mem_access_if.slave  bus
);
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   mem_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             is_ld, mem, mis, timeout;
   logic [7:0]       al_strobe;
   logic [63:0]      al_data;

   mem_store_align u_align (
      .msize (bus.in_msize),
      .addr  (bus.in_addr[2:0]),
      .wdata (bus.in_wdata),
      .strobe(al_strobe),
      .data  (al_data)
   );

   assign mem     = bus.in_is_load | bus.in_is_store;
   assign mis     = mem && mem_misaligned(bus.in_msize, bus.in_addr[2:0]);
   assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == TO_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         cnt              <= '0;
         is_ld            <= 1'b0;
         bus.in_ready     <= 1'b1;
         bus.dreq_valid   <= 1'b0;
         bus.dreq_addr    <= '0;
         bus.dreq_size    <= MSIZE1;
         bus.dreq_strobe  <= '0;
         bus.dreq_data    <= '0;
         bus.out_valid    <= 1'b0;
         bus.out_rd       <= '0;
         bus.out_addr     <= '0;
         bus.out_msize    <= MSIZE1;
         bus.out_unsigned <= 1'b0;
         bus.out_misalign <= 1'b0;
         bus.out_bus_err  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.in_valid) begin
               bus.in_ready     <= 1'b0;
               bus.out_addr     <= bus.in_addr[2:0];
               bus.out_msize    <= bus.in_msize;
               bus.out_unsigned <= bus.in_unsigned;
               bus.out_rd       <= '0;
               bus.out_bus_err  <= 1'b0;
               bus.out_misalign <= mis;
               is_ld            <= bus.in_is_load;
               if (!mem || mis) begin
                  state         <= S_DONE;
                  bus.out_valid <= 1'b1;
               end else begin
                  state           <= S_REQ;
                  cnt             <= '0;
                  bus.dreq_valid  <= 1'b1;
                  bus.dreq_addr   <= bus.in_addr;
                  bus.dreq_size   <= bus.in_msize;
                  bus.dreq_strobe <= bus.in_is_store ? al_strobe : 8'h00;
                  bus.dreq_data   <= bus.in_is_store ? al_data : 64'h0;
               end
            end
            S_REQ, S_WAIT: begin
               cnt <= &cnt ? cnt : cnt + 1'b1;
               // completion wins over a timeout landing on the same cycle
               if (bus.dresp_data_ok && (state == S_WAIT || bus.dresp_addr_ok)) begin
                  state          <= S_DONE;
                  bus.dreq_valid <= 1'b0;
                  bus.out_valid  <= 1'b1;
                  bus.out_rd     <= is_ld ? bus.dresp_data : 64'h0;
               end else if (timeout) begin
                  state           <= S_DONE;
                  bus.dreq_valid  <= 1'b0;
                  bus.out_valid   <= 1'b1;
                  bus.out_bus_err <= 1'b1;
               end else if (state == S_REQ && bus.dresp_addr_ok) begin
                  state          <= S_WAIT;
                  bus.dreq_valid <= 1'b0;
               end
            end
            S_DONE: if (bus.out_ready) begin
               state         <= S_IDLE;
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed checks of mem_access with a 4-cycle bus timeout.
module tb_mem_access;
   import mem_access_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   n;

   always #5 clk = ~clk;

   mem_access_if bus();
   mem_access #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic issue(input logic ld, input logic st, input logic [63:0] a, input logic [63:0] wd, input msize_t sz, input logic u);
      bus.in_valid = 1'b1; bus.in_is_load = ld; bus.in_is_store = st;
      bus.in_addr = a; bus.in_wdata = wd; bus.in_msize = sz; bus.in_unsigned = u;
      cyc();
      bus.in_valid = 1'b0;
   endtask

   task automatic release_out();
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      chk("release in_ready", 64'(bus.in_ready), 64'd1);
      chk("release out_valid", 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      bus.in_valid = 0; bus.in_is_load = 0; bus.in_is_store = 0; bus.in_unsigned = 0;
      bus.in_addr = 0; bus.in_wdata = 0; bus.in_msize = MSIZE1;
      bus.dresp_addr_ok = 0; bus.dresp_data_ok = 0; bus.dresp_data = 0; bus.out_ready = 0;
      cyc(); cyc();
      chk("rst in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst dreq_valid", 64'(bus.dreq_valid), 64'd0);
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst strobe", 64'(bus.dreq_strobe), 64'd0);
      chk("rst out_rd", bus.out_rd, 64'd0);
      rst_n = 1'b1;
      cyc();

      // LB 0x1003, data_ok three cycles after addr_ok
      issue(1, 0, 64'h1003, 64'h0, MSIZE1, 1);
      chk("lb dreq_valid", 64'(bus.dreq_valid), 64'd1);
      chk("lb dreq_addr", bus.dreq_addr, 64'h1003);
      chk("lb strobe", 64'(bus.dreq_strobe), 64'd0);
      chk("lb in_ready", 64'(bus.in_ready), 64'd0);
      bus.dresp_addr_ok = 1;
      cyc();
      bus.dresp_addr_ok = 0;
      chk("lb wait dreq_valid", 64'(bus.dreq_valid), 64'd0);
      cyc(); cyc();
      chk("lb early out_valid", 64'(bus.out_valid), 64'd0);
      bus.dresp_data_ok = 1; bus.dresp_data = 64'h1122_3344_5566_7788;
      cyc();
      bus.dresp_data_ok = 0; bus.dresp_data = 0;
      chk("lb out_valid", 64'(bus.out_valid), 64'd1);
      chk("lb out_rd", bus.out_rd, 64'h1122_3344_5566_7788);
      chk("lb out_addr", 64'(bus.out_addr), 64'd3);
      chk("lb out_unsigned", 64'(bus.out_unsigned), 64'd1);
      chk("lb out_msize", 64'(bus.out_msize), 64'(MSIZE1));
      release_out();

      // SH 0x2006 with addr_ok+data_ok together, then a held result
      issue(0, 1, 64'h2006, 64'hBEEF, MSIZE2, 0);
      chk("sh dreq_valid", 64'(bus.dreq_valid), 64'd1);
      chk("sh strobe", 64'(bus.dreq_strobe), 64'hC0);
      chk("sh data", bus.dreq_data, 64'hBEEF_0000_0000_0000);
      bus.dresp_addr_ok = 1; bus.dresp_data_ok = 1; bus.dresp_data = 64'hDEAD;
      cyc();
      bus.dresp_addr_ok = 0; bus.dresp_data_ok = 0; bus.dresp_data = 0;
      chk("sh out_valid", 64'(bus.out_valid), 64'd1);
      chk("sh dreq_valid drop", 64'(bus.dreq_valid), 64'd0);
      chk("sh out_rd", bus.out_rd, 64'd0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("hold out_valid", 64'(bus.out_valid), 64'd1);
         chk("hold in_ready", 64'(bus.in_ready), 64'd0);
         chk("hold out_addr", 64'(bus.out_addr), 64'd6);
         chk("hold dreq_valid", 64'(bus.dreq_valid), 64'd0);
      end
      release_out();

      // LW 0x3002 misaligned: no bus traffic
      issue(1, 0, 64'h3002, 64'h0, MSIZE4, 0);
      chk("lw out_misalign", 64'(bus.out_misalign), 64'd1);
      chk("lw out_valid", 64'(bus.out_valid), 64'd1);
      chk("lw dreq_valid", 64'(bus.dreq_valid), 64'd0);
      release_out();

      // non-memory op passes straight through
      issue(0, 0, 64'h4005, 64'h0, MSIZE8, 0);
      chk("nop out_valid", 64'(bus.out_valid), 64'd1);
      chk("nop misalign", 64'(bus.out_misalign), 64'd0);
      chk("nop dreq_valid", 64'(bus.dreq_valid), 64'd0);
      release_out();

      // LD with no data_ok: timeout after 4 counted cycles
      issue(1, 0, 64'h5000, 64'h0, MSIZE8, 0);
      chk("to dreq_valid", 64'(bus.dreq_valid), 64'd1);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         cyc();
         n++;
      end
      chk("to out_valid", 64'(bus.out_valid), 64'd1);
      chk("to latency", 64'(n), 64'd5);
      chk("to bus_err", 64'(bus.out_bus_err), 64'd1);
      chk("to out_rd", bus.out_rd, 64'd0);
      chk("to dreq_valid drop", 64'(bus.dreq_valid), 64'd0);
      release_out();

      // reset pulsed while waiting on data
      issue(1, 0, 64'h6008, 64'h0, MSIZE8, 0);
      bus.dresp_addr_ok = 1;
      cyc();
      bus.dresp_addr_ok = 0;
      rst_n = 1'b0;
      #1;
      chk("arst dreq_valid", 64'(bus.dreq_valid), 64'd0);
      chk("arst in_ready", 64'(bus.in_ready), 64'd1);
      cyc();
      rst_n = 1'b1;
      bus.dresp_data_ok = 1; bus.dresp_data = 64'hFFFF;
      cyc();
      bus.dresp_data_ok = 0; bus.dresp_data = 0;
      chk("late out_valid", 64'(bus.out_valid), 64'd0);
      chk("late out_rd", bus.out_rd, 64'd0);
      chk("late in_ready", 64'(bus.in_ready), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
